// File: rtl/mdi_pkg.sv
// Shared types and widths for the MDI register bank controller.
package mdi_pkg;

  localparam int MDI_VAL_W   = 8;
  localparam int MDI_BASIS_W = 2;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_MISMATCH = 2'd1,
    RSP_DEAD     = 2'd2,
    RSP_LOCKED   = 2'd3
  } rsp_status_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PROV  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RESP  = 3'd3,
    ST_FUSE  = 3'd4,
    ST_LOCK  = 3'd5
  } bank_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer one past the winner whenever the grant is consumed.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;

  // Scan downwards so the candidate closest to the pointer is the last one kept.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    valid_o     = 1'b0;
    cand        = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (IW + 1)'(i);
      if (cand >= (IW + 1)'(N)) begin
        cand = cand - (IW + 1)'(N);
      end
      if (req_i[cand[IW-1:0]]) begin
        grant_o                 = '0;
        grant_o[cand[IW-1:0]]   = 1'b1;
        grant_idx_o             = cand[IW-1:0];
        valid_o                 = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && valid_o) begin
      ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mdi_bank_ctrl.sv
// Sequencer/arbiter for a bank of read-once MDI cells: provisioning, basis-matched
// reads with same-cycle value capture, consumed-cell tracking and tamper lockout.
module mdi_bank_ctrl
  import mdi_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_CELLS = 8,
  parameter int IDX_W     = $clog2(NUM_CELLS),
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             prov_valid,
  output logic                             prov_ready,
  input  logic [IDX_W-1:0]                 prov_idx,
  input  logic [MDI_VAL_W-1:0]             prov_value,
  input  logic [MDI_BASIS_W-1:0]           prov_basis,
  output logic                             prov_err,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*IDX_W-1:0]         req_idx,
  input  logic [NUM_REQ*MDI_BASIS_W-1:0]   req_basis,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic [1:0]                       rsp_status,
  output logic [MDI_VAL_W-1:0]             rsp_data,
  output logic [NUM_CELLS-1:0]             cell_init,
  output logic [NUM_CELLS-1:0]             cell_read,
  output logic [NUM_CELLS-1:0]             cell_allow,
  output logic [MDI_VAL_W-1:0]             cell_value_in,
  output logic [MDI_BASIS_W-1:0]           cell_basis_in,
  input  logic [NUM_CELLS*MDI_VAL_W-1:0]   cell_value_out,
  input  logic [NUM_CELLS-1:0]             cell_collapsed,
  input  logic [NUM_CELLS*MDI_BASIS_W-1:0] cell_basis_out,
  input  logic                             tamper,
  output logic [NUM_CELLS-1:0]             cell_fuse_blow,
  output logic                             locked
);

  bank_state_e            state_q, state_d;
  logic [NUM_CELLS-1:0]   dead_q, dead_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [MDI_BASIS_W-1:0] basis_q, basis_d;
  logic [MDI_VAL_W-1:0]   provVal_q, provVal_d;
  logic [ID_W-1:0]        id_q, id_d;
  rsp_status_e            status_q, status_d;
  logic [MDI_VAL_W-1:0]   data_q, data_d;
  logic                   pend_q, pend_d;

  logic [IDX_W-1:0]       reqIdxArr    [NUM_REQ];
  logic [MDI_BASIS_W-1:0] reqBasisArr  [NUM_REQ];
  logic [MDI_VAL_W-1:0]   cellValArr   [NUM_CELLS];
  logic [MDI_BASIS_W-1:0] cellBasisArr [NUM_CELLS];

  logic [NUM_REQ-1:0] arbGrant;
  logic [ID_W-1:0]    arbIdx;
  logic               arbValid;
  logic               arbAdvance;
  logic               basisMatch;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign reqIdxArr[g]   = req_idx[g*IDX_W +: IDX_W];
    assign reqBasisArr[g] = req_basis[g*MDI_BASIS_W +: MDI_BASIS_W];
  end

  for (genvar g = 0; g < NUM_CELLS; g++) begin : g_cell
    assign cellValArr[g]   = cell_value_out[g*MDI_VAL_W +: MDI_VAL_W];
    assign cellBasisArr[g] = cell_basis_out[g*MDI_BASIS_W +: MDI_BASIS_W];
  end

  assign basisMatch = (basis_q == cellBasisArr[idx_q]);

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (req_valid),
    .advance_i   (arbAdvance),
    .grant_o     (arbGrant),
    .grant_idx_o (arbIdx),
    .valid_o     (arbValid)
  );

  always_comb begin
    state_d        = state_q;
    dead_d         = dead_q;
    idx_d          = idx_q;
    basis_d        = basis_q;
    provVal_d      = provVal_q;
    id_d           = id_q;
    status_d       = status_q;
    data_d         = data_q;
    pend_d         = pend_q;
    prov_ready     = 1'b0;
    prov_err       = 1'b0;
    req_ready      = '0;
    arbAdvance     = 1'b0;
    rsp_valid      = 1'b0;
    rsp_id         = '0;
    rsp_status     = RSP_OK;
    rsp_data       = '0;
    cell_init      = '0;
    cell_read      = '0;
    cell_allow     = '0;
    cell_value_in  = '0;
    cell_basis_in  = '0;
    cell_fuse_blow = '0;
    locked         = 1'b0;

    unique case (state_q)
      // Handshakes are suppressed while reset is held so every output reads 0.
      ST_IDLE: begin
        if (!reset) begin
          if (tamper) begin
            state_d = ST_FUSE;
          end else begin
            prov_ready = 1'b1;
            if (prov_valid) begin
              idx_d     = prov_idx;
              basis_d   = prov_basis;
              provVal_d = prov_value;
              state_d   = ST_PROV;
            end else if (arbValid) begin
              req_ready  = arbGrant;
              arbAdvance = 1'b1;
              idx_d      = reqIdxArr[arbIdx];
              basis_d    = reqBasisArr[arbIdx];
              id_d       = arbIdx;
              pend_d     = 1'b1;
              state_d    = ST_ISSUE;
            end
          end
        end
      end
      ST_PROV: begin
        if (dead_q[idx_q]) begin
          prov_err = 1'b1;
        end else begin
          cell_init[idx_q] = 1'b1;
          cell_value_in    = provVal_q;
          cell_basis_in    = basis_q;
        end
        state_d = ST_IDLE;
      end
      // The cell collapses on this edge, so its value must be captured now.
      ST_ISSUE: begin
        if (dead_q[idx_q] || cell_collapsed[idx_q]) begin
          status_d = RSP_DEAD;
          data_d   = '0;
        end else begin
          cell_read[idx_q]  = 1'b1;
          cell_allow[idx_q] = basisMatch;
          dead_d[idx_q]     = 1'b1;
          if (basisMatch) begin
            status_d = RSP_OK;
            data_d   = cellValArr[idx_q];
          end else begin
            status_d = RSP_MISMATCH;
            data_d   = '0;
          end
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid  = 1'b1;
        rsp_id     = id_q;
        rsp_status = status_q;
        rsp_data   = data_q;
        if (rsp_ready) begin
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_FUSE: begin
        cell_fuse_blow = '1;
        dead_d         = '1;
        if (pend_q) begin
          rsp_valid  = 1'b1;
          rsp_id     = id_q;
          rsp_status = RSP_LOCKED;
          status_d   = RSP_LOCKED;
          data_d     = '0;
          if (rsp_ready) begin
            pend_d = 1'b0;
          end
        end
        state_d = ST_LOCK;
      end
      ST_LOCK: begin
        locked = 1'b1;
        if (pend_q) begin
          rsp_valid  = 1'b1;
          rsp_id     = id_q;
          rsp_status = status_q;
          rsp_data   = data_q;
          if (rsp_ready) begin
            pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tamper && (state_q != ST_FUSE) && (state_q != ST_LOCK)) begin
      state_d = ST_FUSE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dead_q    <= '0;
      idx_q     <= '0;
      basis_q   <= '0;
      provVal_q <= '0;
      id_q      <= '0;
      status_q  <= RSP_OK;
      data_q    <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dead_q    <= dead_d;
      idx_q     <= idx_d;
      basis_q   <= basis_d;
      provVal_q <= provVal_d;
      id_q      <= id_d;
      status_q  <= status_d;
      data_q    <= data_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: doc/mdi_bank_ctrl.md
Name: mdi_bank_ctrl

Overview:
Sequencer and arbiter for a bank of NUM_CELLS read-once MDI registers shared by NUM_REQ requesters.
- Provisions cells: value plus prepared basis.
- Round-robin arbitrates read requests.
- Performs basis matching and drives the per-cell allow_read.
- Captures the same-cycle value before collapse.
- Tracks consumed cells and escalates tamper events to a bank-wide fuse blow.
- Sits between the host/protocol engine and the mdi_register array.

Parameters:
NUM_REQ, 4, number of read requesters (>=2)
NUM_CELLS, 8, number of mdi_register instances in the bank (power of 2)
IDX_W, $clog2(NUM_CELLS), cell index width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
prov_valid  in  1  provisioning request
prov_ready  out  1  high in IDLE when not locked
prov_idx  in  IDX_W  target cell
prov_value  in  8  value to store
prov_basis  in  2  prepared basis
prov_err  out  1  1-cycle pulse: provision targeted a dead cell, no init issued
req_valid  in  NUM_REQ  per-requester read request
req_ready  out  NUM_REQ  one-hot grant/accept
req_idx  in  NUM_REQ*IDX_W  requested cell per requester
req_basis  in  NUM_REQ*2  measurement basis per requester
rsp_valid  out  1  response valid, held until rsp_ready
rsp_ready  in  1  response accept
rsp_id  out  $clog2(NUM_REQ)  requester the response belongs to
rsp_status  out  2  0=OK, 1=MISMATCH, 2=DEAD, 3=LOCKED
rsp_data  out  8  captured value; 0 unless status OK
cell_init  out  NUM_CELLS  one-hot init strobe
cell_read  out  NUM_CELLS  one-hot read strobe
cell_allow  out  NUM_CELLS  allow_read, asserted only with the matching cell_read
cell_value_in  out  8  broadcast provisioning value
cell_basis_in  out  2  broadcast provisioning basis
cell_value_out  in  NUM_CELLS*8  per-cell value_out
cell_collapsed  in  NUM_CELLS  per-cell collapsed
cell_basis_out  in  NUM_CELLS*2  per-cell exposed basis
tamper  in  1  tamper detect, level
cell_fuse_blow  out  NUM_CELLS  fuse request, all bits together
locked  out  1  bank permanently disabled until reset

Behaviour:
- Reset values:
  - All outputs 0.
  - dead bitmap 0; rr pointer 0; state IDLE.
  - Reset mid-operation aborts any pending response, which is dropped.
- States:
  - IDLE, PROV, ISSUE, RESP: normal sequencing.
  - FUSE, LOCK: tamper path.
- IDLE:
  - tamper wins over everything and moves to FUSE.
  - Otherwise prov_valid wins over reads; prov_ready=1 and the handshake moves to PROV.
  - Otherwise the round-robin grant picks the first valid requester starting at rr_ptr.
  - The granted requester gets req_ready for 1 cycle; latch idx, basis and id; go to ISSUE.
  - rr_ptr <= grant+1 mod NUM_REQ.
- PROV (1 cycle):
  - If dead[idx]: pulse prov_err, no init issued.
  - Otherwise drive cell_init[idx], cell_value_in and cell_basis_in.
  - Return to IDLE.
- ISSUE (1 cycle):
  - If dead[idx] or cell_collapsed[idx]: no strobe; status DEAD.
  - Otherwise:
    - cell_read[idx]=1.
    - cell_allow[idx] = (req_basis == cell_basis_out[idx]).
    - Capture cell_value_out[idx] this cycle, because the cell collapses on this edge.
    - Set dead[idx].
    - status OK if basis matched, else MISMATCH with data 0 (a mismatched read still consumes the cell).
  - Go to RESP.
- RESP:
  - rsp_valid held with stable fields until rsp_ready, then IDLE.
  - Latency: accept at cycle t, read strobe at t+1, rsp_valid at t+2.
- FUSE (1 cycle):
  - cell_fuse_blow all ones; dead <= all ones.
  - If a response was pending, its status becomes LOCKED.
  - Go to LOCK; tamper in any state preempts to FUSE on the next cycle.
- LOCK:
  - locked=1; prov_ready=0; req_ready=0.
  - A response aborted by tamper is still presented as LOCKED until accepted.
  - Leave only via reset.
- Invariants:
  - At most one bit of cell_init|cell_read is set per cycle.
  - cell_allow is never set without cell_read.
  - The dead bitmap never clears except on reset.
- Index is always < NUM_CELLS, since NUM_CELLS is a power of 2.

Decomposition:
- Package mdi_pkg:
  - rsp_status_e (OK, MISMATCH, DEAD, LOCKED).
  - bank_state_e.
  - MDI_VAL_W=8, MDI_BASIS_W=2.
- Sub-module rr_arbiter (parameter N): req vector, advance strobe, one-hot grant, grant index, internal pointer.

Test Plan:
1. Provision cell 3 with value 0x5A, basis 2; requester 1 reads cell 3 with basis 2 -> cell_read[3] and cell_allow[3] at t+1, rsp_status OK, rsp_data 0x5A, rsp_id 1.
2. Provision cell 5 with basis 1; read with basis 0 -> cell_read[5]=1, cell_allow[5]=0, status MISMATCH, data 0; a second read of cell 5 -> no strobe, status DEAD.
3. Requesters 0, 1 and 3 request continuously -> grants in order 0,1,3,0,...; prov_valid asserted in IDLE is taken before any pending read.
4. Read cell 2, then re-provision cell 2 -> prov_err pulse, cell_init stays 0.
5. Assert tamper during RESP with rsp_ready=0 -> cell_fuse_blow all ones for 1 cycle, pending status LOCKED, locked=1, all ready signals stay 0 until reset.
6. Assert reset in the ISSUE cycle -> next cycle all outputs 0, dead cleared, a cell provisioned afterwards is read back OK.
